// File: rtl/seg_addsub_pipe_if.sv
// Operand/result handshake bundle for seg_addsub_pipe.
// master = source/sink side, slave = the adder pipeline.
interface seg_addsub_pipe_if #(
  parameter int WIDTH = 16,
  parameter int SEG   = 4
);
  localparam int STAGES = WIDTH / SEG;

  logic              in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  a;
  logic [WIDTH-1:0]  b;
  logic              c_in;
  logic              sub;
  logic              out_valid;
  logic              out_ready;
  logic [WIDTH-1:0]  s;
  logic [STAGES-1:0] c_out;
  logic              ovf;

  modport master (
    output in_valid, a, b, c_in, sub, out_ready,
    input  in_ready, out_valid, s, c_out, ovf
  );

  modport slave (
    input  in_valid, a, b, c_in, sub, out_ready,
    output in_ready, out_valid, s, c_out, ovf
  );
endinterface

// File: rtl/seg_addsub_pipe.sv
// Segmented-carry add/sub pipeline, one SEG-bit segment per stage.
// Define ADDSUB_SAT_EN to clamp s on signed overflow.
module seg_addsub_pipe #(
  parameter int WIDTH = 16,
  parameter int SEG   = 4
) (
  input  logic             clk,
  input  logic             reset,
  seg_addsub_pipe_if.slave bus
);
  localparam int STAGES = WIDTH / SEG;

  logic adv;

  assign adv          = ~bus.out_valid | bus.out_ready;
  assign bus.in_ready = adv;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [WIDTH-1:0]  pa;
    logic [WIDTH-1:0]  pb;
    logic [WIDTH-1:0]  ps;
    logic [STAGES-1:0] pc;
    logic              pv;
    logic              ci;
    logic [SEG:0]      part;

    logic [WIDTH-1:0]  r_a;
    logic [WIDTH-1:0]  r_b;
    logic [WIDTH-1:0]  r_sum;
    logic [STAGES-1:0] r_c;
    logic              r_v;

    if (k == 0) begin : g_first
      assign pa = bus.a;
      assign pb = bus.sub ? ~bus.b : bus.b;
      assign ps = '0;
      assign pc = '0;
      assign pv = bus.in_valid;
      assign ci = bus.sub ^ bus.c_in;
    end else begin : g_next
      assign pa = g_stage[k-1].r_a;
      assign pb = g_stage[k-1].r_b;
      assign ps = g_stage[k-1].r_sum;
      assign pc = g_stage[k-1].r_c;
      assign pv = g_stage[k-1].r_v;
      assign ci = g_stage[k-1].r_c[k-1];
    end

    assign part = {1'b0, pa[k*SEG +: SEG]}
                + {1'b0, pb[k*SEG +: SEG]}
                + {{SEG{1'b0}}, ci};

    // operands skew forward whole; the sum fills in one segment per stage
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_v   <= 1'b0;
        r_a   <= '0;
        r_b   <= '0;
        r_sum <= '0;
        r_c   <= '0;
      end else if (adv) begin
        r_v   <= pv;
        r_a   <= pa;
        r_b   <= pb;
        r_sum <= ps;
        r_sum[k*SEG +: SEG] <= part[SEG-1:0];
        r_c   <= pc;
        r_c[k] <= part[SEG];
      end
    end
  end

  logic [WIDTH-1:0] raw;
  logic             sa;
  logic             sb;
  logic             ovf;
  logic             unused_ops;

  assign raw        = g_stage[STAGES-1].r_sum;
  assign sa         = g_stage[STAGES-1].r_a[WIDTH-1];
  assign sb         = g_stage[STAGES-1].r_b[WIDTH-1];
  assign unused_ops = ^{g_stage[STAGES-1].r_a,
                        g_stage[STAGES-1].r_b};
  assign ovf        = (sa == sb) & (raw[WIDTH-1] != sa);

  assign bus.out_valid = g_stage[STAGES-1].r_v;
  assign bus.c_out     = g_stage[STAGES-1].r_c;
  assign bus.ovf       = ovf;

`ifdef ADDSUB_SAT_EN
  assign bus.s = !ovf ? raw
               : sa   ? {1'b1, {(WIDTH-1){1'b0}}}
               :        {1'b0, {(WIDTH-1){1'b1}}};
`else
  assign bus.s = raw;
`endif
endmodule

// File: tb/tb_seg_addsub_pipe.sv
// Scoreboard bench for seg_addsub_pipe (16/4 main, 4/1 side instance).
// Expected results come from a signed/unsigned arithmetic model.
module tb_seg_addsub_pipe;
  typedef struct {
    logic [15:0] s;
    logic [3:0]  c;
    logic        ovf;
    int          cyc;
    bit          lat;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  int   n_in = 0;
  int   n_out = 0;
  exp_t q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  seg_addsub_pipe_if #(.WIDTH(16), .SEG(4)) bus ();
  seg_addsub_pipe_if #(.WIDTH(4), .SEG(1)) bus4 ();

  seg_addsub_pipe #(.WIDTH(16), .SEG(4)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  seg_addsub_pipe #(.WIDTH(4), .SEG(1)) dut4 (
    .clk(clk), .reset(reset), .bus(bus4)
  );

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [15:0] a,
                                 input logic [15:0] b,
                                 input logic ci,
                                 input logic sb);
    exp_t m;
    logic [15:0] be;
    logic ce;
    int sv;
    int lo;
    int msk;
    be = sb ? ~b : b;
    ce = sb ? ~ci : ci;
    if (sb) sv = int'($signed(a)) - int'($signed(b)) - int'(ci);
    else    sv = int'($signed(a)) + int'($signed(b)) + int'(ci);
    m.s = a + be + {15'd0, ce};
    for (int k = 0; k < 4; k++) begin
      msk = (1 << (4 * (k + 1))) - 1;
      lo = (int'(a) & msk) + (int'(be) & msk) + int'(ce);
      m.c[k] = lo[4 * (k + 1)];
    end
    m.ovf = (sv > 32767) || (sv < -32768);
`ifdef ADDSUB_SAT_EN
    if (m.ovf) m.s = (sv > 0) ? 16'h7FFF : 16'h8000;
`endif
    m.cyc = 0;
    m.lat = 0;
    return m;
  endfunction

  task automatic send(input logic [15:0] a, input logic [15:0] b,
                      input logic ci, input logic sb, input bit lat);
    exp_t e;
    int n;
    bit done;
    n = 0;
    done = 0;
    bus.in_valid = 1'b1;
    bus.a = a;
    bus.b = b;
    bus.c_in = ci;
    bus.sub = sb;
    while (!done) begin
      @(negedge clk);
      if (bus.in_ready) begin
        e = model(a, b, ci, sb);
        e.cyc = cyc;
        e.lat = lat;
        q.push_back(e);
        n_in++;
        done = 1;
      end
      @(posedge clk);
      #1;
      n++;
      if (!done && n > 50) begin
        check("send_timeout", {31'd0, bus.in_ready}, 32'd1);
        done = 1;
      end
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("drain_empty", 32'(q.size()), 32'd0);
  endtask

  logic [15:0] hs;
  logic [3:0]  hc;
  logic        ho;
  bit          hp = 0;

  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      hp = 0;
    end else begin
      if (hp) begin
        check("hold_valid", {31'd0, bus.out_valid}, 32'd1);
        check("hold_s", {16'd0, bus.s}, {16'd0, hs});
        check("hold_c", {28'd0, bus.c_out}, {28'd0, hc});
        check("hold_ovf", {31'd0, bus.ovf}, {31'd0, ho});
      end
      if (bus.out_valid && bus.out_ready) begin
        n_out++;
        if (q.size() == 0) begin
          check("unexpected_out", 32'(q.size()), 32'd1);
        end else begin
          e = q.pop_front();
          check("s", {16'd0, bus.s}, {16'd0, e.s});
          check("c_out", {28'd0, bus.c_out}, {28'd0, e.c});
          check("ovf", {31'd0, bus.ovf}, {31'd0, e.ovf});
          if (e.lat) check("latency", 32'(cyc - e.cyc), 32'd4);
        end
      end
      hp = bus.out_valid && !bus.out_ready;
      hs = bus.s;
      hc = bus.c_out;
      ho = bus.ovf;
    end
  end

  initial begin
    int t0;
    int n;
    bus.in_valid = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.c_in = 1'b0;
    bus.sub = 1'b0;
    bus.out_ready = 1'b1;
    bus4.in_valid = 1'b0;
    bus4.a = '0;
    bus4.b = '0;
    bus4.c_in = 1'b0;
    bus4.sub = 1'b0;
    bus4.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    @(negedge clk);
    check("rst_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_s", {16'd0, bus.s}, 32'd0);
    @(posedge clk);
    #1;

    send(16'h1111, 16'h2222, 1'b0, 1'b0, 0);
    send(16'h3333, 16'h4444, 1'b1, 1'b0, 0);
    send(16'h5555, 16'h0101, 1'b0, 1'b1, 0);
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_valid", {31'd0, bus.out_valid}, 32'd0);
    check("mid_rst_s", {16'd0, bus.s}, 32'd0);
    check("mid_rst_c", {28'd0, bus.c_out}, 32'd0);
    check("mid_rst_ovf", {31'd0, bus.ovf}, 32'd0);
    q.delete();
    n_in = 0;
    n_out = 0;
    @(posedge clk);
    #1 reset = 1'b0;

    send(16'h1234, 16'h1111, 1'b0, 1'b0, 1);
    send(16'h00FF, 16'h0001, 1'b0, 1'b0, 1);
    send(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1);
    send(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1);
    send(16'h8000, 16'h0001, 1'b0, 1'b1, 1);
    send(16'h0000, 16'h0000, 1'b1, 1'b1, 1);
    drain();

    fork
      begin
        logic [15:0] ra;
        logic [15:0] rb;
        for (int i = 0; i < 8; i++) begin
          ra = 16'($urandom);
          rb = 16'($urandom);
          send(ra, rb, 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 0);
        end
      end
      begin
        repeat (5) @(posedge clk);
        #1 bus.out_ready = 1'b0;
        @(negedge clk);
        check("stall_in_ready", {31'd0, bus.in_ready}, 32'd0);
        check("stall_out_valid", {31'd0, bus.out_valid}, 32'd1);
        repeat (3) @(posedge clk);
        #1 bus.out_ready = 1'b1;
      end
    join
    drain();
    check("in_out_count", 32'(n_out), 32'(n_in));

    bus4.a = 4'h5;
    bus4.b = 4'h3;
    bus4.c_in = 1'b1;
    bus4.sub = 1'b1;
    bus4.in_valid = 1'b1;
    @(negedge clk);
    t0 = cyc;
    check("w4_in_ready", {31'd0, bus4.in_ready}, 32'd1);
    @(posedge clk);
    #1 bus4.in_valid = 1'b0;
    n = 0;
    @(negedge clk);
    while (!bus4.out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("w4_latency", 32'(cyc - t0), 32'd4);
    check("w4_s", {28'd0, bus4.s}, 32'd1);
    check("w4_c3", {31'd0, bus4.c_out[3]}, 32'd1);
    check("w4_ovf", {31'd0, bus4.ovf}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
